// File: rtl/alu_seq_if.sv
// Request/result bundle for alu_seq: operation handshake in, registered results out.
interface alu_seq_if #(
   parameter int W = 8
);
   logic         valid_i;
   logic         ready_o;
   logic [3:0]   ALU_ctrl;
   logic [W-1:0] A;
   logic [W-1:0] B;
   logic [W-1:0] res_lo;
   logic [W-1:0] res_hi;
   logic         cout;
   logic         zero;
   logic         valid_o;

   modport master (
      output valid_i, ALU_ctrl, A, B,
      input  ready_o, res_lo, res_hi, cout, zero, valid_o
   );

   modport slave (
      input  valid_i, ALU_ctrl, A, B,
      output ready_o, res_lo, res_hi, cout, zero, valid_o
   );
endinterface

// File: rtl/alu_seq.sv
// Multi-cycle ALU: single-cycle logic/arith ops plus iterative shift-add
// multiply and restoring divide, all behind a registered valid/ready handshake.
module alu_seq #(
   parameter int W      = 8,
   parameter bit DIV_EN = 1'b1
) (
   input logic       clk,
   input logic       reset,
   alu_seq_if.slave  bus
);
   localparam int CW = $clog2(W) + 1;

   typedef enum logic {IDLE, BUSY} state_e;

   state_e        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          is_div_q, is_div_d;
   logic [W-1:0]  hi_q, hi_d;
   logic [W-1:0]  lo_q, lo_d;
   logic [W-1:0]  b_q, b_d;
   logic [W-1:0]  res_lo_q, res_lo_d;
   logic [W-1:0]  res_hi_q, res_hi_d;
   logic          cout_q, cout_d;
   logic          valid_q, valid_d;

   logic op_and, op_or, op_add, op_sub;
   logic op_slt, op_nor, op_mul, op_div;

   assign op_and = (bus.ALU_ctrl == 4'd0);
   assign op_or  = (bus.ALU_ctrl == 4'd1);
   assign op_add = (bus.ALU_ctrl == 4'd2);
   assign op_sub = (bus.ALU_ctrl == 4'd6);
   assign op_slt = (bus.ALU_ctrl == 4'd7);
   assign op_nor = (bus.ALU_ctrl == 4'd12);
   assign op_mul = (bus.ALU_ctrl == 4'd3);
   assign op_div = DIV_EN && (bus.ALU_ctrl == 4'd4);

   // sub is A + ~B + 1 so cout matches the carry of the adder
   logic [W:0]   sum;
   logic [W-1:0] sc_lo;
   logic         sc_cout;

   assign sum = {1'b0, bus.A}
              + {1'b0, op_sub ? ~bus.B : bus.B}
              + {{W{1'b0}}, op_sub};

   always_comb begin
      sc_lo   = '0;
      sc_cout = 1'b0;
      unique case (1'b1)
         op_and: sc_lo = bus.A & bus.B;
         op_or:  sc_lo = bus.A | bus.B;
         op_add,
         op_sub: begin
            sc_lo   = sum[W-1:0];
            sc_cout = sum[W];
         end
         op_slt: sc_lo = {{(W-1){1'b0}}, bus.A < bus.B};
         op_nor: sc_lo = ~(bus.A | bus.B);
         default: ;
      endcase
   end

   // mul: {hi,lo} holds partial product with multiplier shifting out of lo
   logic [W:0]   madd;
   logic [W-1:0] mhi, mlo;

   assign madd       = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : '0);
   assign {mhi, mlo} = {madd, lo_q[W-1:1]};

   // div: hi is the remainder, dividend bits shift out of lo as quotient shifts in
   logic [W:0]   dsh;
   logic [W-1:0] dsub, dhi, dlo;
   logic         ge;

   assign dsh  = {hi_q, lo_q[W-1]};
   assign ge   = (dsh >= {1'b0, b_q});
   assign dsub = dsh[W-1:0] - b_q;
   assign dhi  = ge ? dsub : dsh[W-1:0];
   assign dlo  = {lo_q[W-2:0], ge};

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      is_div_d = is_div_q;
      hi_d     = hi_q;
      lo_d     = lo_q;
      b_d      = b_q;
      res_lo_d = res_lo_q;
      res_hi_d = res_hi_q;
      cout_d   = cout_q;
      valid_d  = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (bus.valid_i) begin
               if (op_mul || op_div) begin
                  state_d  = BUSY;
                  cnt_d    = '0;
                  is_div_d = op_div;
                  hi_d     = '0;
                  lo_d     = op_div ? bus.A : bus.B;
                  b_d      = op_div ? bus.B : bus.A;
               end else begin
                  res_lo_d = sc_lo;
                  res_hi_d = '0;
                  cout_d   = sc_cout;
                  valid_d  = 1'b1;
               end
            end
         end
         BUSY: begin
            hi_d  = is_div_q ? dhi : mhi;
            lo_d  = is_div_q ? dlo : mlo;
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CW'(W - 1)) begin
               state_d  = IDLE;
               res_hi_d = hi_d;
               res_lo_d = lo_d;
               cout_d   = 1'b0;
               valid_d  = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         is_div_q <= 1'b0;
         hi_q     <= '0;
         lo_q     <= '0;
         b_q      <= '0;
         res_lo_q <= '0;
         res_hi_q <= '0;
         cout_q   <= 1'b0;
         valid_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         is_div_q <= is_div_d;
         hi_q     <= hi_d;
         lo_q     <= lo_d;
         b_q      <= b_d;
         res_lo_q <= res_lo_d;
         res_hi_q <= res_hi_d;
         cout_q   <= cout_d;
         valid_q  <= valid_d;
      end
   end

   assign bus.ready_o = (state_q == IDLE);
   assign bus.res_lo  = res_lo_q;
   assign bus.res_hi  = res_hi_q;
   assign bus.cout    = cout_q;
   assign bus.zero    = (res_lo_q == '0);
   assign bus.valid_o = valid_q;
endmodule
